// File: rtl/icache_pkg.sv
// Shared definitions for the I-cache refill sequencer: refill FSM state
// encoding, line geometry and PC field positions for a 4-way, 64-set,
// 8-word-line instruction cache.
package icache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int OFF_W      = 3;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 21;

    // PC field positions: word offset, set index, tag
    localparam int OFF_LSB    = 2;
    localparam int OFF_MSB    = 4;
    localparam int IDX_LSB    = 5;
    localparam int IDX_MSB    = 10;
    localparam int TAG_LSB    = 11;
    localparam int TAG_MSB    = 31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FILL   = 3'd2,
        ST_UPD    = 3'd3,
        ST_REPLAY = 3'd4
    } state_t;

    // Word-aligned address of the critical word
    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:OFF_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Beat collector for one cache line. Beats land in slot wr_idx in arrival
// order, so slot 0 always holds the critical word; the cache rotates the
// line into place using the miss offset.
module icache_line_buffer
    import icache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [OFF_W-1:0]             wr_idx,
    input  logic [WORD_W-1:0]            wr_data,
    output logic [LINE_WORDS*WORD_W-1:0] line_flat
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] slot_q;

    // Slot storage: clear wins over a write in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_q <= '0;
        else if (clr)
            slot_q <= '0;
        else if (wr_en)
            slot_q[wr_idx] <= wr_data;
    end

    assign line_flat = slot_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer between IF, the I-cache and main memory. A fetch
// miss stalls IF, issues one critical-word-first burst, collects the line,
// installs it in the cache and replays the fetch. A redirect before grant
// abandons the miss silently; after grant the line is still installed but
// the replay is skipped.
// Optional build macro: ICACHE_PERF_CNT_EN adds saturating miss and
// stall-cycle counters; without it perf_miss/perf_stall are tied to 0.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [31:0]                  fetch_pc,
    input  logic                         redirect,
    output logic                         fetch_stall,
    output logic [31:0]                  cache_pc,
    output logic                         cache_rd,
    input  logic                         cache_hit,
    output logic                         cache_upd,
    input  logic                         cache_upd_ok,
    output logic [LINE_WORDS*WORD_W-1:0] line_data,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [WORD_W-1:0]            mem_rdata,
    output logic [31:0]                  perf_miss,
    output logic [31:0]                  perf_stall
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t           state_q, state_d;
    logic [31:0]      miss_pc_q;
    logic [OFF_W-1:0] beat_cnt_q;
    logic             squash_q, squash_d;
    logic             new_miss;   // entering REQ: a miss is being counted
    logic             grant;      // burst accepted this cycle
    logic             buf_wr;     // beat captured this cycle

    // Next state and outputs; IDLE outputs follow IF combinationally, and are
    // forced low while reset is held so every output is 0 during reset
    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        new_miss    = 1'b0;
        grant       = 1'b0;
        buf_wr      = 1'b0;
        fetch_stall = 1'b0;
        cache_rd    = 1'b0;
        cache_pc    = miss_pc_q;
        cache_upd   = 1'b0;
        mem_req     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cache_pc    = reset ? '0 : fetch_pc;
                cache_rd    = fetch_req & ~reset;
                fetch_stall = fetch_req & ~cache_hit & ~reset;
                if (fetch_req && !cache_hit && !redirect) begin
                    state_d  = ST_REQ;
                    new_miss = 1'b1;
                end
            end
            ST_REQ: begin
                mem_req     = 1'b1;
                fetch_stall = 1'b1;
                if (mem_gnt) begin
                    // grant beats a simultaneous redirect; it just squashes
                    grant    = 1'b1;
                    squash_d = redirect;
                    state_d  = ST_FILL;
                end else if (redirect) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                fetch_stall = 1'b1;
                buf_wr      = mem_rvalid;
                if (redirect)
                    squash_d = 1'b1;
                if (mem_rvalid && beat_cnt_q == LAST_BEAT)
                    state_d = ST_UPD;
            end
            ST_UPD: begin
                fetch_stall = 1'b1;
                cache_upd   = 1'b1;
                if (redirect)
                    squash_d = 1'b1;
                if (cache_upd_ok)
                    state_d = (squash_q || redirect) ? ST_IDLE : ST_REPLAY;
            end
            ST_REPLAY: begin
                cache_rd    = 1'b1;
                fetch_stall = ~cache_hit;
                if (redirect || cache_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_REQ;
                    new_miss = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE)
            squash_d = 1'b0;
    end

    // State, miss PC, beat counter and squash flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            miss_pc_q  <= '0;
            beat_cnt_q <= '0;
            squash_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            if (new_miss && state_q == ST_IDLE)
                miss_pc_q <= fetch_pc;
            if (grant)
                beat_cnt_q <= '0;
            else if (buf_wr)
                beat_cnt_q <= beat_cnt_q + OFF_W'(1);
        end
    end

    assign mem_addr = word_addr(miss_pc_q);

    icache_line_buffer u_line_buf (
        .clk       (clk),
        .rst       (reset),
        .clr       (new_miss),
        .wr_en     (buf_wr),
        .wr_idx    (beat_cnt_q),
        .wr_data   (mem_rdata),
        .line_flat (line_data)
    );

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_miss_q, perf_stall_q;

    // Saturating miss and stall-cycle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_miss_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (new_miss && perf_miss_q != 32'hFFFF_FFFF)
                perf_miss_q <= perf_miss_q + 32'd1;
            if (fetch_stall && perf_stall_q != 32'hFFFF_FFFF)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_miss  = perf_miss_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_miss  = '0;
    assign perf_stall = '0;
`endif

endmodule
